// File: rtl/c_gate_array_sync_if.sv
// c_gate_array_sync_if: lane inputs, lane outputs and the completion done/ack handshake.
// Latency: none; this is a plain signal bundle.
// Backpressure: phase_done is held until the consumer drives ack.
interface c_gate_array_sync_if #(
    parameter int WIDTH = 3,
    parameter int LANES = 4
);
    logic [LANES*WIDTH-1:0] in_put;
    logic [LANES-1:0]       out_put;
    logic                   phase_target;
    logic                   phase_done;
    logic                   ack;

    // Producer/consumer side: drives lane inputs and ack, observes outputs.
    modport master (
        output in_put,
        output ack,
        input  out_put,
        input  phase_target,
        input  phase_done
    );

    // C-element array side.
    modport slave (
        input  in_put,
        input  ack,
        output out_put,
        output phase_target,
        output phase_done
    );
endinterface

// File: rtl/c_gate_array_sync.sv
// c_gate_array_sync: LANES clocked WIDTH-input Muller C-elements with consensus filter and done/ack completion detector.
// Latency: a lane toggles FILTER-1 edges after the edge that first samples a consensus; phase_done rises one cycle after all lanes match.
// Backpressure: phase_done holds until ack is taken; transition stats ports exist only when C_GATE_ARRAY_STATS_EN is defined.
module c_gate_array_sync #(
    parameter int               WIDTH     = 3,
    parameter int               LANES     = 4,
    parameter logic [LANES-1:0] C_INIT    = '0,
    parameter logic [WIDTH-1:0] PLUS_MASK = '0,
    parameter int               FILTER    = 1
) (
    input  logic                  clk,
    input  logic                  preset,
`ifdef C_GATE_ARRAY_STATS_EN
    input  logic                  stats_clear,
    output logic [LANES*16-1:0]   stats_trans,
`endif
    c_gate_array_sync_if.slave    bus
);

    // Parameter sanity checks at elaboration time.
    if (WIDTH < 2) begin : g_bad_width
        $error("c_gate_array_sync: WIDTH must be >= 2");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("c_gate_array_sync: LANES must be >= 1");
    end
    if (FILTER < 1 || FILTER > 15) begin : g_bad_filter
        $error("c_gate_array_sync: FILTER must be in 1..15");
    end
    if (PLUS_MASK == {WIDTH{1'b1}}) begin : g_bad_plus
        $error("c_gate_array_sync: PLUS_MASK must leave at least one input in the reset condition");
    end

    localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

    logic [LANES-1:0] out_q;
    logic [LANES-1:0] cand;
    logic [LANES-1:0] fire;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] lane_in;
        logic             set_c;
        logic             rst_c;
        logic             lane_q;
        logic [3:0]       cnt_q;

        assign lane_in  = bus.in_put[i*WIDTH +: WIDTH];
        // Plus inputs help set the lane but are masked out of the reset NOR.
        assign set_c    = &lane_in;
        assign rst_c    = ~|(lane_in & ~PLUS_MASK);
        assign cand[i]  = lane_q ? rst_c : set_c;
        assign fire[i]  = cand[i] && (cnt_q == FILT_LAST);
        assign out_q[i] = lane_q;

        // Count consecutive consensus cycles; toggle the lane when the run completes, restart on any gap.
        always_ff @(posedge clk) begin
            if (preset) begin
                lane_q <= C_INIT[i];
                cnt_q  <= '0;
            end else if (fire[i]) begin
                lane_q <= ~lane_q;
                cnt_q  <= '0;
            end else if (cand[i]) begin
                cnt_q  <= cnt_q + 4'd1;
            end else begin
                cnt_q  <= '0;
            end
        end

`ifdef C_GATE_ARRAY_STATS_EN
        logic [15:0] trans_q;

        // Saturating per-lane toggle count; a clear beats a same-edge increment.
        always_ff @(posedge clk) begin
            if (preset || stats_clear) begin
                trans_q <= '0;
            end else if (fire[i] && trans_q != 16'hFFFF) begin
                trans_q <= trans_q + 16'd1;
            end
        end

        assign stats_trans[i*16 +: 16] = trans_q;
`endif
    end

    logic target_q;
    logic done_q;
    logic all_match;
    logic ack_take;

    assign all_match = (out_q == {LANES{target_q}});
    assign ack_take  = bus.ack && done_q;

    // Completion detector: flag when every lane reaches the target phase, flip the target when the flag is acknowledged.
    always_ff @(posedge clk) begin
        if (preset) begin
            target_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (ack_take) begin
            target_q <= ~target_q;
            done_q   <= 1'b0;
        end else begin
            done_q   <= all_match;
        end
    end

    assign bus.out_put      = out_q;
    assign bus.phase_target = target_q;
    assign bus.phase_done   = done_q;

endmodule

// File: tb/tb_c_gate_array_sync.sv
// tb_c_gate_array_sync: directed checks of four parameterisations of the C-element array.
// Latency: inputs applied after an edge, outputs sampled 1 time unit after the next edge.
// Backpressure: ack driven directly from the vector table and hand sequences.
module tb_c_gate_array_sync;

    logic clk;
    logic preset;
`ifdef C_GATE_ARRAY_STATS_EN
    logic        stats_clear;
    logic [63:0] stats_a, stats_b, stats_c, stats_d;
`endif

    int n_checks;
    int n_fail;

    c_gate_array_sync_if #(.WIDTH(3), .LANES(4)) if_a ();
    c_gate_array_sync_if #(.WIDTH(3), .LANES(4)) if_b ();
    c_gate_array_sync_if #(.WIDTH(3), .LANES(4)) if_c ();
    c_gate_array_sync_if #(.WIDTH(3), .LANES(4)) if_d ();

    // Defaults: FILTER=1, C_INIT=0, no plus inputs.
    c_gate_array_sync #(.WIDTH(3), .LANES(4)) dut_a (
        .clk(clk), .preset(preset),
`ifdef C_GATE_ARRAY_STATS_EN
        .stats_clear(stats_clear), .stats_trans(stats_a),
`endif
        .bus(if_a)
    );

    // Glitch filter.
    c_gate_array_sync #(.WIDTH(3), .LANES(4), .FILTER(3)) dut_b (
        .clk(clk), .preset(preset),
`ifdef C_GATE_ARRAY_STATS_EN
        .stats_clear(stats_clear), .stats_trans(stats_b),
`endif
        .bus(if_b)
    );

    // Asymmetric input 2.
    c_gate_array_sync #(.WIDTH(3), .LANES(4), .PLUS_MASK(3'b100)) dut_c (
        .clk(clk), .preset(preset),
`ifdef C_GATE_ARRAY_STATS_EN
        .stats_clear(stats_clear), .stats_trans(stats_c),
`endif
        .bus(if_c)
    );

    // Mixed initial state with filter.
    c_gate_array_sync #(.WIDTH(3), .LANES(4), .FILTER(3), .C_INIT(4'b1010)) dut_d (
        .clk(clk), .preset(preset),
`ifdef C_GATE_ARRAY_STATS_EN
        .stats_clear(stats_clear), .stats_trans(stats_d),
`endif
        .bus(if_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] in_put;
        logic        ack;
        logic [3:0]  out_put;
        logic        target;
        logic        done;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [3:0] o, input logic t, input logic d);
        check({tag, ".out"},    64'(if_d.out_put),      64'(o));
        check({tag, ".target"}, 64'(if_d.phase_target), 64'(t));
        check({tag, ".done"},   64'(if_d.phase_done),   64'(d));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        preset   = 1'b1;
`ifdef C_GATE_ARRAY_STATS_EN
        stats_clear = 1'b0;
`endif
        if_a.in_put = '0; if_a.ack = 1'b0;
        if_b.in_put = '0; if_b.ack = 1'b0;
        if_c.in_put = '0; if_c.ack = 1'b0;
        if_d.in_put = '0; if_d.ack = 1'b0;

        // Dut A vectors: basic C-element behaviour and completion handshake.
        vecs[0]  = '{12'h007, 1'b0, 4'b0001, 1'b1, 1'b0};
        vecs[1]  = '{12'h005, 1'b0, 4'b0001, 1'b1, 1'b0};
        vecs[2]  = '{12'h000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{12'hFFF, 1'b0, 4'b1111, 1'b1, 1'b0};
        vecs[4]  = '{12'hFFF, 1'b0, 4'b1111, 1'b1, 1'b1};
        vecs[5]  = '{12'hFFF, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[6]  = '{12'hFFF, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[7]  = '{12'hFFF, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[8]  = '{12'h000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{12'h000, 1'b0, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{12'h000, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[11] = '{12'hB6D, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[12] = '{12'hE38, 1'b0, 4'b1010, 1'b1, 1'b0};

        // Reset state of every instance.
        step();
        check("rst_a.out",    64'(if_a.out_put),      64'(4'b0000));
        check("rst_a.target", 64'(if_a.phase_target), 64'(1'b1));
        check("rst_a.done",   64'(if_a.phase_done),   64'(1'b0));
        check("rst_b.out",    64'(if_b.out_put),      64'(4'b0000));
        check_d("rst_d", 4'b1010, 1'b1, 1'b0);
        preset = 1'b0;

        // Table-driven run on dut A.
        for (int i = 0; i < 13; i++) begin
            if_a.in_put = vecs[i].in_put;
            if_a.ack    = vecs[i].ack;
            step();
            check($sformatf("vec%0d.out", i),    64'(if_a.out_put),      64'(vecs[i].out_put));
            check($sformatf("vec%0d.target", i), 64'(if_a.phase_target), 64'(vecs[i].target));
            check($sformatf("vec%0d.done", i),   64'(if_a.phase_done),   64'(vecs[i].done));
        end
        if_a.ack = 1'b0;

        // Dut B: FILTER=3 on lane1, one-cycle dropout restarts the count.
        preset = 1'b1; step(); preset = 1'b0;
        if_b.in_put = 12'h038; step(); check("flt.run1a", 64'(if_b.out_put[1]), 64'(1'b0));
        step();                        check("flt.run1b", 64'(if_b.out_put[1]), 64'(1'b0));
        if_b.in_put = 12'h030; step(); check("flt.gap",   64'(if_b.out_put[1]), 64'(1'b0));
        if_b.in_put = 12'h038; step(); check("flt.run2a", 64'(if_b.out_put[1]), 64'(1'b0));
        step();                        check("flt.run2b", 64'(if_b.out_put[1]), 64'(1'b0));
        step();                        check("flt.run2c", 64'(if_b.out_put[1]), 64'(1'b1));
        if_b.in_put = 12'h000; step(); check("flt.fall1", 64'(if_b.out_put[1]), 64'(1'b1));
        step();                        check("flt.fall2", 64'(if_b.out_put[1]), 64'(1'b1));
        step();                        check("flt.fall3", 64'(if_b.out_put[1]), 64'(1'b0));
        check("flt.others", 64'(if_b.out_put), 64'(4'b0000));

        // Dut C: input 2 of each lane sets only; it does not block the reset condition.
        preset = 1'b1; step(); preset = 1'b0;
        if_c.in_put = 12'h1C0; step(); check("plus.set",     64'(if_c.out_put[2]), 64'(1'b1));
        if_c.in_put = 12'h040; step(); check("plus.hold",    64'(if_c.out_put[2]), 64'(1'b1));
        if_c.in_put = 12'h000; step(); check("plus.clr",     64'(if_c.out_put[2]), 64'(1'b0));
        if_c.in_put = 12'h0C0; step(); check("plus.noset",   64'(if_c.out_put[2]), 64'(1'b0));
        if_c.in_put = 12'h1C0; step(); check("plus.set2",    64'(if_c.out_put[2]), 64'(1'b1));
        if_c.in_put = 12'h100; step(); check("plus.ignored", 64'(if_c.out_put[2]), 64'(1'b0));

        // Dut D: preset mid-count and while phase_done/ack are pending.
        preset = 1'b1; step(); preset = 1'b0;
        if_d.in_put = 12'hFFF;
        step(); check_d("mid.c1", 4'b1010, 1'b1, 1'b0);
        step(); check_d("mid.c2", 4'b1010, 1'b1, 1'b0);
        preset = 1'b1; step(); check_d("mid.rst", 4'b1010, 1'b1, 1'b0);
        preset = 1'b0;
        step(); check_d("re.c1", 4'b1010, 1'b1, 1'b0);
        step(); check_d("re.c2", 4'b1010, 1'b1, 1'b0);
        step(); check_d("re.c3", 4'b1111, 1'b1, 1'b0);
        step(); check_d("re.done", 4'b1111, 1'b1, 1'b1);
        preset = 1'b1; if_d.ack = 1'b1;
        step(); check_d("done.rst", 4'b1010, 1'b1, 1'b0);
        preset = 1'b0; if_d.ack = 1'b0;
        step(); check_d("done.after", 4'b1010, 1'b1, 1'b0);

`ifdef C_GATE_ARRAY_STATS_EN
        // Lane3 transition counter on dut A.
        preset = 1'b1; step(); preset = 1'b0;
        check("stats.rst", stats_a, 64'd0);
        for (int k = 0; k < 5; k++) begin
            if_a.in_put = (k % 2 == 0) ? 12'hE00 : 12'h000;
            step();
        end
        check("stats.five", 64'(stats_a[63:48]), 64'd5);
        check("stats.lane0", 64'(stats_a[15:0]), 64'd0);
        if_a.in_put = 12'h000; stats_clear = 1'b1;
        step(); check("stats.clear", 64'(stats_a[63:48]), 64'd0);
        check("stats.clr_out", 64'(if_a.out_put[3]), 64'(1'b0));
        stats_clear = 1'b0; if_a.in_put = 12'hE00;
        step(); check("stats.one", 64'(stats_a[63:48]), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
